// File: rtl/mem_bridge.sv
// ---------------------------------------------------------------------------
// mem_bridge
//   Bridges the multicycle CPU memory port to a variable-latency req/ack
//   memory. Stores are posted into a circular write buffer and drained in
//   order; loads stall the CPU until the buffer is empty and the load data
//   has come back. Every memory transaction is followed by one idle cycle.
//
// Parameters
//   WB_DEPTH  write-buffer entries (power of 2, >= 2)
//   TIMEOUT   ack-wait limit in cycles (only with MEM_TIMEOUT_EN)
//
// Optional build macro
//   MEM_TIMEOUT_EN  abort a transaction after TIMEOUT cycles without ack,
//                   raise sticky mem_err, return 32'hDEADBEEF on a read.
//
// Ports
//   clk, rst                  clock, async active-low reset
//   cpu_req/we/adr/wdata      CPU access request
//   cpu_rdata, cpu_stall      read data, stall back to the CPU
//   mem_req/we/adr/wdata      registered memory request
//   mem_ack, mem_rdata        memory completion and read data
//   wb_count                  buffered write count (debug)
//   mem_err                   sticky timeout flag
// ---------------------------------------------------------------------------
module mem_bridge #(
    parameter int WB_DEPTH = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cpu_req,
    input  logic                        cpu_we,
    input  logic [31:0]                 cpu_adr,
    input  logic [31:0]                 cpu_wdata,
    output logic [31:0]                 cpu_rdata,
    output logic                        cpu_stall,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [31:0]                 mem_adr,
    output logic [31:0]                 mem_wdata,
    input  logic                        mem_ack,
    input  logic [31:0]                 mem_rdata,
    output logic [$clog2(WB_DEPTH):0]   wb_count,
    output logic                        mem_err
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    if (WB_DEPTH < 2 || (WB_DEPTH & (WB_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("mem_bridge: WB_DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, WRITE, READ, GAP} state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } wb_entry_t;

    state_t        state, state_d;
    wb_entry_t     wb_mem [WB_DEPTH];
    wb_entry_t     head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, enq, deq;
    logic          busy, done, tmo, rd_done, rd_pend;
    logic          start_wr, start_rd;

    // full comes from the registered count, so a dequeue in this cycle only
    // frees space for a stalled store on the next cycle.
    assign full      = (count == CW'(WB_DEPTH));
    assign empty     = (count == '0);
    assign enq       = cpu_req & cpu_we & ~full;
    assign rd_pend   = cpu_req & ~cpu_we & ~rd_done;
    assign cpu_stall = cpu_req & (cpu_we ? full : ~rd_done);
    assign head      = wb_mem[rd_ptr];
    assign wb_count  = count;

    // mem_req is high exactly while in WRITE/READ, so an ack outside those
    // states never completes anything.
    assign busy = (state == WRITE) || (state == READ);
    assign done = busy & (mem_ack | tmo);
    assign deq  = (state == WRITE) & done;

    // ---------------- write buffer ----------------
    always_ff @(posedge clk) begin
        if (enq) wb_mem[wr_ptr] <= '{adr: cpu_adr, data: cpu_wdata};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // Buffered stores always go first so a load never overtakes an older store.
    always_comb begin
        state_d  = state;
        start_wr = 1'b0;
        start_rd = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_d  = WRITE;
                    start_wr = 1'b1;
                end else if (rd_pend) begin
                    state_d  = READ;
                    start_rd = 1'b1;
                end
            end
            WRITE, READ: if (done) state_d = GAP;
            GAP:         state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // ---------------- registered memory / CPU outputs ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            rd_done   <= 1'b0;
        end else begin
            if (start_wr) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_adr   <= head.adr;
                mem_wdata <= head.data;
            end else if (start_rd) begin
                mem_req <= 1'b1;
                mem_we  <= 1'b0;
                mem_adr <= cpu_adr;
            end else if (done) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end

            // One-cycle pulse releases the stalled load; cleared next edge.
            rd_done <= (state == READ) & done;

            if (state == READ) begin
                if (mem_ack)  cpu_rdata <= mem_rdata;
                else if (tmo) cpu_rdata <= 32'hDEAD_BEEF;
            end
        end
    end

    // ---------------- optional ack timeout ----------------
`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tcnt;
    logic          err_q;

    // Abort on the edge where the wait count would reach TIMEOUT, so mem_req
    // stays up for exactly TIMEOUT cycles without an ack.
    assign tmo     = busy & ~mem_ack & (tcnt == TW'(TIMEOUT - 1));
    assign mem_err = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            if (start_wr || start_rd)  tcnt <= '0;
            else if (busy && !mem_ack) tcnt <= tcnt + TW'(1);
            if (tmo) err_q <= 1'b1;
        end
    end
`else
    assign tmo     = 1'b0;
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_mem_bridge
//   Directed bench for mem_bridge. Stores are pushed into a scoreboard queue
//   when the CPU side accepts them and popped when the memory model acks the
//   matching write. The memory model acks after ack_dly wait cycles.
// ---------------------------------------------------------------------------
module tb_mem_bridge;

    localparam int WB_DEPTH = 4;
    localparam int CW       = $clog2(WB_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [31:0]   cpu_adr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_adr;
    logic [31:0]   mem_wdata;
    logic          mem_ack = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic [CW-1:0] wb_count;
    logic          mem_err;

    mem_bridge #(.WB_DEPTH(WB_DEPTH), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wb_count  (wb_count),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- memory model + scoreboard ----------------
    int          ack_dly = 0;
    bit          never_ack = 1'b0;
    int          wait_cnt = 0;
    bit          prev_ack = 1'b0;
    int          writes_seen = 0;
    int          read_ack_cyc = -1;
    int          wb_peak = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mem_model [logic [31:0]];

    always @(negedge clk) begin
        logic [63:0] e;
        if (int'(wb_count) > wb_peak) wb_peak = int'(wb_count);
        // at least one idle cycle after every completed transaction
        if (prev_ack) chk("gap_after_ack", {31'd0, mem_req}, 32'd0);
        if (mem_req && !never_ack) begin
            // a load may only go out once every older store has completed
            if (!mem_we && wait_cnt == 0) chk("read_after_drain", 32'(exp_q.size()), 32'd0);
            if (wait_cnt >= ack_dly) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        failures++;
                        $error("FAIL unexpected_write got=%h:%h exp=none", mem_adr, mem_wdata);
                    end
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("wr_adr", mem_adr, e[63:32]);
                        chk("wr_data", mem_wdata, e[31:0]);
                    end
                    mem_model[mem_adr] = mem_wdata;
                    writes_seen++;
                end else begin
                    mem_rdata = mem_model.exists(mem_adr) ? mem_model[mem_adr] : 32'h0;
                    read_ack_cyc = cyc;
                end
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wait_cnt = 0;
        end
        prev_ack = mem_ack;
    end

    // ---------------- CPU-side tasks (called at posedge + #1) ----------------
    task automatic cpu_write(input logic [31:0] adr, input logic [31:0] data, output int stalls);
        stalls = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = adr; cpu_wdata = data;
        forever begin
            @(negedge clk);
            if (!cpu_stall) break;
            stalls++;
            if (stalls > 200) begin
                chk("write_stall_bound", 32'(stalls), 32'd0);
                break;
            end
            @(posedge clk); #1;
        end
        exp_q.push_back({adr, data});
        @(posedge clk); #1;
    endtask

    task automatic cpu_read(input logic [31:0] adr, output int stalls,
                            output logic [31:0] data, output int drop_cyc);
        stalls = 0; data = '0; drop_cyc = -1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = adr;
        forever begin
            @(negedge clk);
            if (!cpu_stall) begin
                data = cpu_rdata;
                drop_cyc = cyc;
                break;
            end
            stalls++;
            if (stalls > 200) begin
                chk("read_stall_bound", 32'(stalls), 32'd0);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic cpu_idle();
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        for (int i = 0; i < 200 && writes_seen < n; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int          st;
        int          dc;
        int          base;
        logic [31:0] rd;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
        chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
        chk("rst_mem_adr",   mem_adr,            32'd0);
        chk("rst_mem_wdata", mem_wdata,          32'd0);
        chk("rst_cpu_rdata", cpu_rdata,          32'd0);
        chk("rst_wb_count",  32'(wb_count),      32'd0);
        chk("rst_stall",     {31'd0, cpu_stall}, 32'd0);
        chk("rst_mem_err",   {31'd0, mem_err},   32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // four posted stores, then a fifth into a full buffer
        ack_dly = 3;
        cpu_write(32'h10, 32'hA, st); chk("post0_stall", 32'(st), 32'd0);
        cpu_write(32'h14, 32'hB, st); chk("post1_stall", 32'(st), 32'd0);
        cpu_write(32'h18, 32'hC, st); chk("post2_stall", 32'(st), 32'd0);
        cpu_write(32'h1C, 32'hD, st); chk("post3_stall", 32'(st), 32'd0);
        // full for the cycle after the 4th enqueue and the dequeue cycle
        cpu_write(32'h24, 32'hE, st); chk("full_stall", 32'(st), 32'd2);
        cpu_idle();
        wait_writes(5);
        chk("writes_total", 32'(writes_seen), 32'd5);
        chk("wb_peak",      32'(wb_peak),     32'd4);
        chk("q_drained",    32'(exp_q.size()), 32'd0);
        chk("wb_empty",     32'(wb_count),    32'd0);

        // read after write: load waits for the store, returns stored data
        cpu_write(32'h20, 32'h1234, st);
        cpu_read(32'h20, st, rd, dc);
        chk("raw_data", rd, 32'h1234);
        chk("raw_drop", 32'(dc - read_ack_cyc), 32'd1);
        cpu_idle();
        repeat (3) @(posedge clk); #1;

        // load with immediate ack, empty buffer
        ack_dly = 0;
        mem_model[32'h40] = 32'h55AA;
        cpu_read(32'h40, st, rd, dc);
        chk("lat0_stall", 32'(st), 32'd2);
        chk("lat0_data",  rd,      32'h55AA);
        chk("lat0_drop",  32'(dc - read_ack_cyc), 32'd1);
        cpu_idle();
        repeat (4) @(posedge clk); #1;
        chk("rdata_hold", cpu_rdata, 32'h55AA);
        chk("idle_stall", {31'd0, cpu_stall}, 32'd0);

        // reset in the middle of a write with another store still buffered
        ack_dly = 10;
        cpu_write(32'h80, 32'h99, st);
        cpu_write(32'h84, 32'h77, st);
        cpu_idle();
        for (int i = 0; i < 20 && !mem_req; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_wr_active", {31'd0, mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_req",   {31'd0, mem_req},   32'd0);
        chk("mid_rst_count", 32'(wb_count),      32'd0);
        chk("mid_rst_stall", {31'd0, cpu_stall}, 32'd0);
        exp_q.delete();
        base = writes_seen;
        @(posedge clk); #1;
        rst = 1'b1;
        ack_dly = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("no_write_after_rst", 32'(writes_seen), 32'(base));
        chk("post_rst_req",       {31'd0, mem_req}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        // memory never acks: abort after 8 wait cycles
        never_ack = 1'b1;
        cpu_read(32'h44, st, rd, dc);
        chk("tmo_data",  rd,                32'hDEAD_BEEF);
        chk("tmo_stall", 32'(st),           32'd9);
        chk("tmo_err",   {31'd0, mem_err},  32'd1);
        cpu_idle();
        never_ack = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("tmo_err_sticky", {31'd0, mem_err}, 32'd1);
`else
        chk("mem_err_tied", {31'd0, mem_err}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Sits directly downstream of the multicycle CPU core, between its data/instruction memory port (adr, writedata, MemWrite, readdata) and a variable-latency memory with a req/ack handshake.
- Posts CPU writes into a small FIFO write buffer so stores do not stall unless the buffer is full.
- Stalls CPU reads until every buffered write has drained and the read data has returned.

Parameters:
- WB_DEPTH, 4, write-buffer entries; power of 2, minimum 2.
- TIMEOUT, 255, ack-wait limit in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU access valid this cycle.
- cpu_we  in  1  1 = write (from MemWrite), 0 = read.
- cpu_adr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data returned to the CPU.
- cpu_stall  out  1  CPU must hold its request and state.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_adr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_ack  in  1  memory completion, sampled on the rising edge.
- mem_rdata  in  32  memory read data, valid when mem_ack=1 on a read.
- wb_count  out  $clog2(WB_DEPTH)+1  buffered write count (debug).
- mem_err  out  1  sticky timeout flag; constant 0 without MEM_TIMEOUT_EN.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; buffer emptied.
  - mem_req=0, mem_we=0, mem_adr=0, mem_wdata=0, cpu_rdata=0, wb_count=0, mem_err=0, rd_done=0.
  - cpu_stall is combinational and reads 0 while cpu_req=0.
  - Reset mid-transaction abandons the transaction; pending buffered writes are discarded.
- Write posting:
  - cpu_req=1, cpu_we=1, buffer not full: {cpu_adr, cpu_wdata} enqueued at the edge, cpu_stall=0 in that cycle.
  - Buffer full: cpu_stall=1 combinationally and no enqueue.
  - A dequeue in the same cycle does not free space for the stalled write until the next cycle.
- Read:
  - cpu_stall = cpu_req & ~cpu_we & ~rd_done (combinational).
  - The read is issued only when FSM=IDLE and the buffer is empty; writes always drain first, preserving program order.
  - On mem_ack in READ: cpu_rdata <= mem_rdata and rd_done <= 1 for exactly one cycle, which drops cpu_stall.
  - rd_done clears on the following edge.
  - cpu_rdata holds its value until the next read completes.
- FSM states: IDLE, WRITE, READ, GAP.
  - IDLE -> WRITE when the buffer is non-empty (head presented on mem_adr/mem_wdata, mem_we=1, mem_req=1).
  - Otherwise IDLE -> READ when a stalled read is pending (mem_we=0, mem_req=1).
  - WRITE -> GAP on mem_ack; the head entry is dequeued at that edge.
  - READ -> GAP on mem_ack.
  - GAP -> IDLE unconditionally. mem_req=0 in GAP, so there is at least one idle cycle between transactions.
- Handshake:
  - mem_req, mem_we, mem_adr and mem_wdata are registered and held stable while mem_req=1 until mem_ack is sampled high.
  - mem_req deasserts on the edge that samples mem_ack.
  - mem_ack while mem_req=0 is ignored.
- Buffer:
  - Circular; read/write pointers are $clog2(WB_DEPTH) bits and wrap modulo WB_DEPTH.
  - wb_count = enqueues - dequeues, range 0..WB_DEPTH.
  - Simultaneous enqueue and dequeue (not full) leaves wb_count unchanged.
- Minimum latencies:
  - Posted write: 0 CPU stall cycles.
  - Read with empty buffer and memory ack in the cycle after mem_req rises: cpu_stall high for 2 cycles.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined:
  - A counter starts at 0 when entering WRITE or READ and increments each cycle mem_ack=0.
  - When it reaches TIMEOUT the transaction is aborted: FSM -> GAP and mem_err <= 1 (sticky until reset).
  - A timed-out write is dequeued (lost).
  - A timed-out read returns cpu_rdata=32'hDEADBEEF with rd_done=1.
- When undefined: no counter is built, the bridge waits for mem_ack indefinitely, and mem_err is tied to 0.

Test Plan:
- Reset: assert rst=0 mid-WRITE -> mem_req=0, wb_count=0, cpu_stall=0 immediately; no write completes after rst=1.
- Posted writes: 4 back-to-back writes (0x10->0xA, 0x14->0xB, 0x18->0xC, 0x1C->0xD), mem ack delay 3 -> no stall on these 4, wb_count peaks at 4, memory sees them in order, gap of >=1 cycle between mem_req pulses.
- Full buffer: 5th write while wb_count=4 -> cpu_stall=1 until the first dequeue edge, then enqueued; total 5 memory writes.
- Read after write: write 0x20->0x1234 then read 0x20 -> read issued only after the write ack, cpu_rdata=0x1234, cpu_stall drops exactly one cycle after the read ack.
- Read with ack latency 0 and empty buffer: read 0x40 (mem_rdata=0x55AA) -> cpu_stall high for exactly 2 cycles.
- With MEM_TIMEOUT_EN and TIMEOUT=8, memory never acks a read -> abort after 8 cycles, cpu_rdata=0xDEADBEEF, mem_err=1 and stays 1.
